// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, instruction field positions, encoder error
// codes and encoder state encoding.
package isa_pkg;

    typedef enum logic [4:0] {
        OP_MV   = 5'b00000,
        OP_ADD  = 5'b00001,
        OP_SUB  = 5'b00010,
        OP_CMP  = 5'b00011,
        OP_LD   = 5'b00100,
        OP_ST   = 5'b00101,
        OP_JR   = 5'b01000,
        OP_JZR  = 5'b01001,
        OP_JNR  = 5'b01010,
        OP_MVI  = 5'b10000,
        OP_ADDI = 5'b10001,
        OP_SUBI = 5'b10010,
        OP_CMPI = 5'b10011,
        OP_MVHI = 5'b10110,
        OP_J    = 5'b11000,
        OP_JZ   = 5'b11001,
        OP_JN   = 5'b11010
    } opcode_e;

    localparam int OP_LSB    = 0;
    localparam int RX_LSB    = 5;
    localparam int RY_LSB    = 8;
    localparam int IMM8_LSB  = 8;
    localparam int IMM11_LSB = 5;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_RANGE   = 2'b10;

    typedef enum logic [1:0] {
        ST_READY,
        ST_EMIT_LO,
        ST_EMIT_HI,
        ST_ERR
    } enc_state_e;

    // An immediate fits a signed field when every bit above the field's sign
    // bit copies it.
    function automatic logic fits_imm8(input logic [15:0] v);
        return (&v[15:7]) | ~(|v[15:7]);
    endfunction

    function automatic logic fits_imm11(input logic [15:0] v);
        return (&v[15:10]) | ~(|v[15:10]);
    endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Combinational packer: symbolic fields to machine word(s), plus opcode
// legality, immediate range check and wide-mvi split detection.
module instr_word_pack
    import isa_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [2:0]  rx,
    input  logic [2:0]  ry,
    input  logic [15:0] imm,
    input  logic        wide,
    output logic [15:0] word_lo,
    output logic [15:0] word_hi,
    output logic        two_word,
    output logic        illegal_op,
    output logic        range_err
);

    logic ok8;
    logic ok11;

    assign ok8  = fits_imm8(imm);
    assign ok11 = fits_imm11(imm);

    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        word_lo    = '0;
        word_hi    = '0;
        two_word   = 1'b0;
        illegal_op = 1'b0;
        range_err  = 1'b0;

        word_lo[OP_LSB +: 5] = op;

        // Upper half of a split mvi is always mvhi rx, imm[15:8].
        word_hi[OP_LSB +: 5]   = OP_MVHI;
        word_hi[RX_LSB +: 3]   = rx;
        word_hi[IMM8_LSB +: 8] = imm[15:8];

        case (op)
            OP_MV, OP_ADD, OP_SUB, OP_CMP, OP_LD, OP_ST: begin
                word_lo[RX_LSB +: 3] = rx;
                word_lo[RY_LSB +: 3] = ry;
            end
            OP_JR, OP_JZR, OP_JNR: begin
                word_lo[RX_LSB +: 3] = rx;
            end
            OP_MVI: begin
                word_lo[RX_LSB +: 3]   = rx;
                word_lo[IMM8_LSB +: 8] = imm[7:0];
                if (!ok8) begin
                    if (wide) two_word  = 1'b1;
                    else      range_err = 1'b1;
                end
            end
            OP_ADDI, OP_SUBI, OP_CMPI: begin
                word_lo[RX_LSB +: 3]   = rx;
                word_lo[IMM8_LSB +: 8] = imm[7:0];
                range_err              = !ok8;
            end
            OP_MVHI: begin
                word_lo[RX_LSB +: 3]   = rx;
                word_lo[IMM8_LSB +: 8] = imm[7:0];
            end
            OP_J, OP_JZ, OP_JN: begin
                word_lo[IMM11_LSB +: 11] = imm[10:0];
                range_err                = !ok11;
            end
            default: illegal_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder: accepts symbolic instructions and writes the
// packed words to instruction memory at an auto-incrementing byte address.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [2:0]        in_rx,
    input  logic [2:0]        in_ry,
    input  logic [15:0]       in_imm,
    input  logic              in_wide,
    input  logic              base_load,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_wait,
    output logic              busy,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  word_count
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);

    enc_state_e  state;
    logic [4:0]  f_op;
    logic [2:0]  f_rx;
    logic [2:0]  f_ry;
    logic [15:0] f_imm;
    logic        f_wide;

    logic [4:0]  pk_op;
    logic [2:0]  pk_rx;
    logic [2:0]  pk_ry;
    logic [15:0] pk_imm;
    logic        pk_wide;
    logic [15:0] word_lo;
    logic [15:0] word_hi;
    logic        two_word;
    logic        illegal_op;
    logic        range_err;
    logic        ready_st;

    assign ready_st = (state == ST_READY);

    // One packer serves both phases: in READY it checks the offered inputs to
    // pick the next state; while emitting it builds words from held fields.
    assign pk_op   = ready_st ? in_op   : f_op;
    assign pk_rx   = ready_st ? in_rx   : f_rx;
    assign pk_ry   = ready_st ? in_ry   : f_ry;
    assign pk_imm  = ready_st ? in_imm  : f_imm;
    assign pk_wide = ready_st ? in_wide : f_wide;

    instr_word_pack u_pack (
        .op         (pk_op),
        .rx         (pk_rx),
        .ry         (pk_ry),
        .imm        (pk_imm),
        .wide       (pk_wide),
        .word_lo    (word_lo),
        .word_hi    (word_hi),
        .two_word   (two_word),
        .illegal_op (illegal_op),
        .range_err  (range_err)
    );

    assign in_ready  = ready_st && !base_load;
    assign mem_wr    = (state == ST_EMIT_LO) || (state == ST_EMIT_HI);
    assign busy      = !ready_st;
    assign err_valid = (state == ST_ERR);
    assign mem_wdata = (state == ST_EMIT_LO) ? word_lo :
                       (state == ST_EMIT_HI) ? word_hi : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_READY;
            f_op       <= '0;
            f_rx       <= '0;
            f_ry       <= '0;
            f_imm      <= '0;
            f_wide     <= 1'b0;
            mem_addr   <= '0;
            word_count <= '0;
            err_code   <= ERR_NONE;
        end else begin
            case (state)
                ST_READY: begin
                    if (base_load) begin
                        mem_addr <= base_addr & ALIGN_MASK;
                    end else if (in_valid) begin
                        f_op   <= in_op;
                        f_rx   <= in_rx;
                        f_ry   <= in_ry;
                        f_imm  <= in_imm;
                        f_wide <= in_wide;
                        if (illegal_op) begin
                            err_code <= ERR_ILLEGAL;
                            state    <= ST_ERR;
                        end else if (range_err) begin
                            err_code <= ERR_RANGE;
                            state    <= ST_ERR;
                        end else begin
                            state    <= ST_EMIT_LO;
                        end
                    end
                end
                ST_EMIT_LO: begin
                    if (!mem_wait) begin
                        mem_addr   <= mem_addr + ADDR_W'(2);
                        word_count <= word_count + CNT_W'(1);
                        state      <= two_word ? ST_EMIT_HI : ST_READY;
                    end
                end
                ST_EMIT_HI: begin
                    if (!mem_wait) begin
                        mem_addr   <= mem_addr + ADDR_W'(2);
                        word_count <= word_count + CNT_W'(1);
                        state      <= ST_READY;
                    end
                end
                default: state <= ST_READY;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed instructions, an arithmetic
// reference encoder and a per-cycle output compare.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [2:0]  in_rx;
    logic [2:0]  in_ry;
    logic [15:0] in_imm;
    logic        in_wide;
    logic        base_load;
    logic [15:0] base_addr;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wait;
    logic        busy;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [15:0] word_count;

    instr_encoder #(.ADDR_W(16), .CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rx      (in_rx),
        .in_ry      (in_ry),
        .in_imm     (in_imm),
        .in_wide    (in_wide),
        .base_load  (base_load),
        .base_addr  (base_addr),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wait   (mem_wait),
        .busy       (busy),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Expected outputs for the current cycle.
    bit          chk_en = 1'b0;
    logic        exp_mem_wr, exp_busy, exp_err_valid, exp_in_ready;
    logic [15:0] exp_wdata, exp_addr, exp_count;
    logic [1:0]  exp_err_code;

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_wr",     mem_wr,     exp_mem_wr);
            check("mem_addr",   mem_addr,   exp_addr);
            check("mem_wdata",  mem_wdata,  exp_wdata);
            check("busy",       busy,       exp_busy);
            check("err_valid",  err_valid,  exp_err_valid);
            check("err_code",   err_code,   exp_err_code);
            check("word_count", word_count, exp_count);
            check("in_ready",   in_ready,   exp_in_ready);
        end
    end

    // Reference encoder in plain integer arithmetic.
    function automatic void encode(input int op, input int rx, input int ry,
                                   input logic [15:0] imm, input bit wide,
                                   output int n, output logic [15:0] w0,
                                   output logic [15:0] w1, output logic [1:0] err);
        int s;
        int u;
        s   = int'($signed(imm));
        u   = int'(imm);
        n   = 1;
        w0  = '0;
        w1  = '0;
        err = 2'd0;
        case (op)
            0, 1, 2, 3, 4, 5: w0 = 16'(ry * 256 + rx * 32 + op);
            8, 9, 10:         w0 = 16'(rx * 32 + op);
            16: begin
                if (s >= -128 && s <= 127) w0 = 16'((u % 256) * 256 + rx * 32 + op);
                else if (wide) begin
                    n  = 2;
                    w0 = 16'((u % 256) * 256 + rx * 32 + op);
                    w1 = 16'((u / 256) * 256 + rx * 32 + 22);
                end else err = 2'd2;
            end
            17, 18, 19: begin
                if (s >= -128 && s <= 127) w0 = 16'((u % 256) * 256 + rx * 32 + op);
                else err = 2'd2;
            end
            22: w0 = 16'((u % 256) * 256 + rx * 32 + op);
            24, 25, 26: begin
                if (s >= -1024 && s <= 1023) w0 = 16'((u % 2048) * 32 + op);
                else err = 2'd2;
            end
            default: err = 2'd1;
        endcase
        if (err != 2'd0) n = 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        exp_mem_wr    = 1'b0;
        exp_wdata     = '0;
        exp_busy      = 1'b0;
        exp_err_valid = 1'b0;
        exp_in_ready  = !base_load;
    endtask

    task automatic set_emit(input logic [15:0] w);
        exp_mem_wr    = 1'b1;
        exp_wdata     = w;
        exp_busy      = 1'b1;
        exp_err_valid = 1'b0;
        exp_in_ready  = 1'b0;
    endtask

    task automatic drive_fields(input logic [4:0] op, input logic [2:0] rx, input logic [2:0] ry,
                                input logic [15:0] imm, input bit wide);
        in_op   = op;
        in_rx   = rx;
        in_ry   = ry;
        in_imm  = imm;
        in_wide = wide;
    endtask

    task automatic load_base(input logic [15:0] addr);
        base_load = 1'b1;
        base_addr = addr;
        set_idle();
        step();
        base_load = 1'b0;
        exp_addr  = addr & 16'hFFFE;
        set_idle();
    endtask

    // Offer one instruction; waits stalls the first word, poke_load pulses a
    // base_load that the encoder must ignore while writing.
    task automatic send(input logic [4:0] op, input logic [2:0] rx, input logic [2:0] ry,
                        input logic [15:0] imm, input bit wide, input int waits, input bit poke_load);
        int n;
        int reps;
        logic [15:0] w0, w1;
        logic [1:0]  err;
        encode(int'(op), int'(rx), int'(ry), imm, wide, n, w0, w1, err);
        in_valid = 1'b1;
        drive_fields(op, rx, ry, imm, wide);
        set_idle();
        step();
        in_valid = 1'b0;
        drive_fields(5'($urandom), 3'($urandom), 3'($urandom), 16'($urandom), 1'($urandom));
        if (err != 2'd0) begin
            exp_err_code  = err;
            exp_err_valid = 1'b1;
            exp_mem_wr    = 1'b0;
            exp_wdata     = '0;
            exp_busy      = 1'b1;
            exp_in_ready  = 1'b0;
            step();
        end else begin
            for (int i = 0; i < n; i++) begin
                reps = (i == 0) ? waits : 0;
                for (int k = 0; k <= reps; k++) begin
                    mem_wait = (k < reps);
                    if (poke_load && i == 0 && k == 0) begin
                        base_load = 1'b1;
                        base_addr = 16'h4000;
                    end
                    set_emit((i == 0) ? w0 : w1);
                    step();
                    base_load = 1'b0;
                    if (!mem_wait) begin
                        exp_addr  = exp_addr + 16'd2;
                        exp_count = exp_count + 16'd1;
                    end
                end
            end
        end
        mem_wait = 1'b0;
        set_idle();
    endtask

    initial begin
        int n;
        logic [15:0] w0, w1;
        logic [1:0]  err;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        base_load = 1'b0;
        base_addr = '0;
        mem_wait  = 1'b0;
        drive_fields(5'd0, 3'd0, 3'd0, 16'd0, 1'b0);
        exp_addr     = '0;
        exp_count    = '0;
        exp_err_code = 2'b00;
        set_idle();
        chk_en = 1'b1;
        step();
        step();
        reset_n = 1'b1;
        step();

        // Hand-computed values that pin the reference encoder.
        encode(1, 1, 2, 16'h0000, 1'b0, n, w0, w1, err);
        check("pin_add", w0, 16'h0221);
        encode(16, 3, 0, 16'h1234, 1'b1, n, w0, w1, err);
        check("pin_mviw_n", n, 2);
        check("pin_mviw_lo", w0, 16'h3470);
        check("pin_mviw_hi", w1, 16'h1276);
        encode(16, 3, 0, 16'hFFF0, 1'b1, n, w0, w1, err);
        check("pin_mvi_neg", {n[15:0], w0}, {16'd1, 16'hF070});
        encode(17, 1, 0, 16'd200, 1'b0, n, w0, w1, err);
        check("pin_addi_rng", err, 2'b10);
        encode(12, 0, 0, 16'd0, 1'b0, n, w0, w1, err);
        check("pin_illegal", err, 2'b01);
        encode(24, 0, 0, 16'hFFFC, 1'b0, n, w0, w1, err);
        check("pin_j", w0, 16'hFF98);

        load_base(16'h0100);
        send(5'b00001, 3'd1, 3'd2, 16'h0000, 1'b0, 0, 1'b0);
        check("lit_count_add", word_count, 16'd1);
        check("lit_addr_add", mem_addr, 16'h0102);

        load_base(16'h0100);
        send(5'b10000, 3'd3, 3'd0, 16'h1234, 1'b1, 0, 1'b0);
        send(5'b10000, 3'd3, 3'd0, 16'hFFF0, 1'b1, 0, 1'b0);
        check("lit_count_mvi", word_count, 16'd4);

        send(5'b10001, 3'd1, 3'd0, 16'd200, 1'b0, 0, 1'b0);
        check("lit_errcode_hold", err_code, 2'b10);
        send(5'b01100, 3'd0, 3'd0, 16'd0, 1'b0, 0, 1'b0);
        send(5'b10001, 3'd2, 3'd0, 16'hFF80, 1'b0, 0, 1'b0);
        send(5'b10011, 3'd2, 3'd0, 16'h0080, 1'b0, 0, 1'b0);
        send(5'b11000, 3'd0, 3'd0, 16'h03FF, 1'b0, 0, 1'b0);
        send(5'b11010, 3'd0, 3'd0, 16'h0400, 1'b0, 0, 1'b0);
        send(5'b10000, 3'd4, 3'd0, 16'd200, 1'b0, 0, 1'b0);

        send(5'b11000, 3'd0, 3'd0, 16'hFFFC, 1'b0, 3, 1'b1);

        load_base(16'hFFFE);
        send(5'b10000, 3'd3, 3'd0, 16'h1234, 1'b1, 0, 1'b0);
        check("lit_wrap_addr", mem_addr, 16'h0002);

        load_base(16'h0201);
        send(5'b00010, 3'd7, 3'd7, 16'h0000, 1'b0, 1, 1'b0);

        // base_load and in_valid together: the load wins, accept follows.
        base_load = 1'b1;
        base_addr = 16'h0300;
        in_valid  = 1'b1;
        drive_fields(5'b00011, 3'd5, 3'd6, 16'h0000, 1'b0);
        set_idle();
        step();
        base_load = 1'b0;
        exp_addr  = 16'h0300;
        send(5'b00011, 3'd5, 3'd6, 16'h0000, 1'b0, 0, 1'b0);

        send(5'b01000, 3'd4, 3'd0, 16'hFFFF, 1'b0, 0, 1'b0);
        send(5'b10110, 3'd2, 3'd0, 16'hABCD, 1'b0, 0, 1'b0);
        send(5'b00100, 3'd6, 3'd1, 16'h0000, 1'b0, 0, 1'b0);
        send(5'b00101, 3'd0, 3'd3, 16'h0000, 1'b0, 2, 1'b0);
        send(5'b11001, 3'd0, 3'd0, 16'h0010, 1'b0, 0, 1'b0);
        send(5'b11111, 3'd1, 3'd1, 16'h0000, 1'b0, 0, 1'b0);

        // Reset during the second word of a split mvi.
        encode(16, 5, 0, 16'hABCD, 1'b1, n, w0, w1, err);
        in_valid = 1'b1;
        drive_fields(5'b10000, 3'd5, 3'd0, 16'hABCD, 1'b1);
        set_idle();
        step();
        in_valid = 1'b0;
        set_emit(w0);
        step();
        exp_addr  = exp_addr + 16'd2;
        exp_count = exp_count + 16'd1;
        set_emit(w1);
        @(negedge clk);
        #1;
        reset_n      = 1'b0;
        exp_addr     = '0;
        exp_count    = '0;
        exp_err_code = 2'b00;
        set_idle();
        step();
        check("lit_rst_addr", mem_addr, 16'h0000);
        check("lit_rst_wr", mem_wr, 1'b0);
        step();
        reset_n = 1'b1;
        step();
        step();
        step();
        check("lit_rst_count", word_count, 16'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Sequential instruction encoder, the inverse of the CPU control decoder. It accepts symbolic instructions (opcode, Rx, Ry, immediate) over a valid/ready handshake and packs each into 16-bit machine words, expanding wide mvi into mvi+mvhi. It writes the words into instruction memory at an auto-incrementing byte address. It is used by the program loader and self-test harness to build programs in memory for the CPU.

Parameters:
ADDR_W, 16, width of mem_addr (byte address; wraps mod 2^ADDR_W)
CNT_W, 16, width of word_count

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction offered
in_ready  out  1  encoder can accept this cycle
in_op  in  5  ISA opcode
in_rx  in  3  Rx field
in_ry  in  3  Ry field
in_imm  in  16  immediate, two's complement
in_wide  in  1  mvi only: full 16-bit immediate requested
base_load  in  1  load write pointer
base_addr  in  ADDR_W  new write pointer (bit0 ignored, forced 0)
mem_wr  out  1  memory write strobe
mem_addr  out  ADDR_W  write byte address
mem_wdata  out  16  encoded word
mem_wait  in  1  memory stall; hold current write
busy  out  1  encoding/writing in progress
err_valid  out  1  one-cycle error pulse
err_code  out  2  01 illegal opcode, 10 immediate out of range
word_count  out  CNT_W  words written since reset (wraps)

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low. Reset values: state READY, mem_wr 0, mem_addr 0, mem_wdata 0, busy 0, err_valid 0, err_code 00, word_count 0. in_ready is 1 from the first cycle after reset deassertion.
- Word formats:
  - R-type (mv, add, sub, cmp, ld, st): {5'b0, ry, rx, op}.
  - Register jump (jr, jzr, jnr): {8'b0, rx, op}.
  - imm8 (mvi, addi, subi, cmpi, mvhi): {imm[7:0], rx, op}.
  - imm11 (j, jz, jn): {imm[10:0], op}.
- Legal opcodes: 00000 mv, 00001 add, 00010 sub, 00011 cmp, 00100 ld, 00101 st, 10000 mvi, 10001 addi, 10010 subi, 10011 cmpi, 10110 mvhi, 01000 jr, 01001 jzr, 01010 jnr, 11000 j, 11001 jz, 11010 jn. Every other opcode is illegal.
- Range checks:
  - addi/subi/cmpi, and mvi with in_wide=0: imm must satisfy imm[15:7] all-equal.
  - imm11 ops: imm[15:10] all-equal.
  - mvhi: only imm[7:0] is used; no check.
  - mvi with in_wide=1: if imm[15:7] is all-equal, emit one word. Otherwise emit two words: mvi rx,imm[7:0], then mvhi rx,imm[15:8].
- State machine: READY, EMIT_LO, EMIT_HI, ERR.
  - READY:
    - in_ready = !base_load.
    - base_load has priority: mem_addr <= {base_addr[ADDR_W-1:1],0}, no accept that cycle.
    - Accept on in_valid && in_ready. Fields are registered, and the word(s) are computed from the registered fields.
    - Legal instruction -> EMIT_LO. Illegal opcode or range failure -> ERR.
  - EMIT_LO / EMIT_HI:
    - mem_wr=1, mem_wdata=word, busy=1, in_ready=0.
    - While mem_wait=1: hold mem_wr, mem_addr and mem_wdata stable.
    - On the cycle with mem_wait=0: mem_addr += 2 (wrapping), word_count += 1.
    - Next state: EMIT_HI if a second word is pending, else READY.
  - ERR: err_valid=1 for exactly one cycle with err_code set. No mem_wr; mem_addr unchanged; next state READY. err_code holds its value until the next error.
- Latency: accept at cycle t, first mem_wr at t+1. Throughput is one word per cycle without stalls, so a one-word instruction is accepted at most every 2 cycles.
- base_load outside READY is ignored.
- Reset asserted mid-operation: all state clears immediately; any pending second word is discarded.

Decomposition:
- Shared package isa_pkg holds:
  - opcode constants or enum (shared with opcode_decoder);
  - field positions (OP_LSB=0, RX_LSB=5, RY_LSB=8, IMM8_LSB=8, IMM11_LSB=5);
  - err_code constants;
  - the encoder state enum.
- One combinational sub-module, instr_word_pack, performs packing, legality check, range check and two-word detection. The top level holds the FSM, pointer and counter.

Test Plan:
- add rx=1 ry=2 after base_load 0x0100 -> single mem_wr, addr 0x0100, wdata 0x0221; word_count 1.
- mvi wide rx=3 imm=0x1234 -> writes 0x3470 @0x0100, then 0x1276 @0x0102 on consecutive cycles. mvi wide imm=0xFFF0 -> single word 0xF070.
- addi imm=200 -> err_valid pulse, err_code 10, no mem_wr, addr unchanged. in_op=01100 -> err_code 01.
- j imm=-4 -> wdata 0xFF98. mem_wait held 3 cycles during the write -> mem_wr/addr/wdata stable, in_ready 0, then advance.
- base_addr=0xFFFE then two words -> addresses 0xFFFE then 0x0000 (wrap). base_load with in_valid in the same cycle -> load wins, instruction accepted next cycle.
- reset_n low during EMIT_HI of wide mvi -> all outputs at reset values, second word never written, mem_addr 0.
